exe_stage: RTL

- Execute stage. Sits directly downstream of the ID/EXE pipeline register and consumes all of its outputs.
- Single-cycle ALU ops and branch resolution are combinational. MUL/DIV-class ops run in an iterative 32-step unit that holds the pipeline through stall_o.
- Produces the ALU result, branch redirect, and forwarded control to the EXE/MEM register.

---
 rtl/exe_stage_pkg.sv | 29 ++
 rtl/exe_stage_muldiv_unit.sv | 135 +++++++++++++
 rtl/exe_stage.sv | 97 +++++++++
 3 files changed

// File: rtl/exe_stage_pkg.sv
// Shared types for the execute stage: widths, ALU/branch encodings and mul/div FSM states.
package exe_stage_pkg;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned ITER   = XLEN;

    localparam logic [XLEN-1:0] RESET_VECTOR = '0;

    // Eleven single-cycle ops plus six mul/div ops need a 5-bit code.
    typedef enum logic [4:0] {
        AluAdd, AluSub, AluAnd, AluOr, AluXor, AluSll, AluSrl, AluSra,
        AluSlt, AluSltu, AluPassb,
        AluMul, AluMulhu, AluDiv, AluDivu, AluRem, AluRemu
    } ctrALU;

    typedef enum logic [3:0] {
        BrNone, BrBeq, BrBne, BrBlt, BrBge, BrBltu, BrBgeu, BrJal, BrJalr
    } ctrBranch;

    typedef enum logic [1:0] {
        StIdle, StBusy, StDone
    } mdState;

    function automatic logic isMulDiv(input ctrALU op);
        return op inside {AluMul, AluMulhu, AluDiv, AluDivu, AluRem, AluRemu};
    endfunction

endpackage

// File: rtl/exe_stage_muldiv_unit.sv
// Iterative 32-step multiplier / restoring divider. Holds the pipeline via busy until done.
module muldiv_unit
    import exe_stage_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  ctrALU           op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int unsigned CntW = $clog2(ITER);
    localparam logic [XLEN-1:0] MinInt = {1'b1, {(XLEN-1){1'b0}}};

    mdState            stateQ, stateD;
    logic [CntW-1:0]   countQ, countD;
    ctrALU             opQ, opD;
    logic [XLEN-1:0]   operandQ, operandD;
    logic [2*XLEN-1:0] accQ, accD;
    logic              negQuoQ, negQuoD, negRemQ, negRemD;

    logic            isDiv, isSigned, isDivQ;
    logic [XLEN-1:0] absA, absB, quo, rem;
    logic [XLEN:0]   mulSum, divShift, divDiff;

    always_comb begin
        isDiv    = op inside {AluDiv, AluDivu, AluRem, AluRemu};
        isSigned = op inside {AluDiv, AluRem};
        isDivQ   = opQ inside {AluDiv, AluDivu, AluRem, AluRemu};
        absA     = (isSigned && a[XLEN-1]) ? -a : a;
        absB     = (isSigned && b[XLEN-1]) ? -b : b;
        // acc holds {remainder, quotient} for divide and {product hi, product lo} for multiply.
        mulSum   = {1'b0, accQ[2*XLEN-1:XLEN]} + {1'b0, operandQ};
        divShift = accQ[2*XLEN-1:XLEN-1];
        divDiff  = divShift - {1'b0, operandQ};
        quo      = accQ[XLEN-1:0];
        rem      = accQ[2*XLEN-1:XLEN];
    end

    always_comb begin
        stateD   = stateQ;
        countD   = countQ;
        opD      = opQ;
        operandD = operandQ;
        accD     = accQ;
        negQuoD  = negQuoQ;
        negRemD  = negRemQ;
        busy     = 1'b0;
        done     = 1'b0;
        unique case (stateQ)
            StIdle: begin
                if (start) begin
                    busy    = 1'b1;
                    opD     = op;
                    countD  = '0;
                    negQuoD = isSigned && (a[XLEN-1] ^ b[XLEN-1]);
                    negRemD = isSigned && a[XLEN-1];
                    if (isDiv && b == '0) begin
                        accD    = {a, {XLEN{1'b1}}};
                        negQuoD = 1'b0;
                        negRemD = 1'b0;
                        stateD  = StDone;
                    end else if (isSigned && a == MinInt && b == {XLEN{1'b1}}) begin
                        accD    = {{XLEN{1'b0}}, MinInt};
                        negQuoD = 1'b0;
                        negRemD = 1'b0;
                        stateD  = StDone;
                    end else begin
                        operandD = isDiv ? absB : a;
                        accD     = {{XLEN{1'b0}}, (isDiv ? absA : b)};
                        stateD   = StBusy;
                    end
                end
            end
            StBusy: begin
                busy = 1'b1;
                if (isDivQ) begin
                    if (!divDiff[XLEN]) begin
                        accD = {divDiff[XLEN-1:0], accQ[XLEN-2:0], 1'b1};
                    end else begin
                        accD = {divShift[XLEN-1:0], accQ[XLEN-2:0], 1'b0};
                    end
                end else if (accQ[0]) begin
                    accD = {mulSum, accQ[XLEN-1:1]};
                end else begin
                    accD = {1'b0, accQ[2*XLEN-1:1]};
                end
                if (countQ == CntW'(ITER - 1)) begin
                    stateD = StDone;
                end else begin
                    countD = countQ + 1'b1;
                end
            end
            StDone: begin
                done   = 1'b1;
                stateD = StIdle;
            end
            default: stateD = StIdle;
        endcase
    end

    always_comb begin
        unique case (opQ)
            AluMulhu:        result = rem;
            AluDiv, AluDivu: result = negQuoQ ? -quo : quo;
            AluRem, AluRemu: result = negRemQ ? -rem : rem;
            default:         result = quo;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            stateQ   <= StIdle;
            countQ   <= '0;
            opQ      <= AluAdd;
            operandQ <= RESET_VECTOR;
            accQ     <= {RESET_VECTOR, RESET_VECTOR};
            negQuoQ  <= 1'b0;
            negRemQ  <= 1'b0;
        end else begin
            stateQ   <= stateD;
            countQ   <= countD;
            opQ      <= opD;
            operandQ <= operandD;
            accQ     <= accD;
            negQuoQ  <= negQuoD;
            negRemQ  <= negRemD;
        end
    end

endmodule

// File: rtl/exe_stage.sv
// Execute stage: combinational ALU and branch resolution, iterative mul/div, output gating.
module exe_stage
    import exe_stage_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_exe,
    input  logic              registerWriteEnable_i,
    input  logic              dataWriteEnable_i,
    input  logic              regSelect_i,
    input  ctrBranch          branchCtr_i,
    input  ctrALU             aluCtr_i,
    input  logic [XLEN-1:0]   dataA_i,
    input  logic [XLEN-1:0]   dataB_i,
    input  logic [ADDR_W-1:0] offset_i,
    output logic [XLEN-1:0]   result_o,
    output logic [XLEN-1:0]   storeData_o,
    output logic              registerWriteEnable_o,
    output logic              dataWriteEnable_o,
    output logic              regSelect_o,
    output logic              branchTaken_o,
    output logic [ADDR_W-1:0] branchTarget_o,
    output logic              stall_o
);

    logic              mdStart, mdBusy, mdDone;
    logic [XLEN-1:0]   mdResult, aluResult;
    logic              cmpTrue, isJump;
    logic [ADDR_W-1:0] jumpSum;

    assign mdStart = rst && isMulDiv(aluCtr_i);

    muldiv_unit u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (mdStart),
        .op     (aluCtr_i),
        .a      (dataA_i),
        .b      (dataB_i),
        .busy   (mdBusy),
        .done   (mdDone),
        .result (mdResult)
    );

    always_comb begin
        aluResult = '0;
        unique case (aluCtr_i)
            AluAdd:   aluResult = dataA_i + dataB_i;
            AluSub:   aluResult = dataA_i - dataB_i;
            AluAnd:   aluResult = dataA_i & dataB_i;
            AluOr:    aluResult = dataA_i | dataB_i;
            AluXor:   aluResult = dataA_i ^ dataB_i;
            AluSll:   aluResult = dataA_i << dataB_i[4:0];
            AluSrl:   aluResult = dataA_i >> dataB_i[4:0];
            AluSra:   aluResult = $signed(dataA_i) >>> dataB_i[4:0];
            AluSlt:   aluResult = {{(XLEN-1){1'b0}}, $signed(dataA_i) < $signed(dataB_i)};
            AluSltu:  aluResult = {{(XLEN-1){1'b0}}, dataA_i < dataB_i};
            AluPassb: aluResult = dataB_i;
            default:  aluResult = '0;
        endcase
    end

    always_comb begin
        cmpTrue = 1'b0;
        unique case (branchCtr_i)
            BrBeq:         cmpTrue = dataA_i == dataB_i;
            BrBne:         cmpTrue = dataA_i != dataB_i;
            BrBlt:         cmpTrue = $signed(dataA_i) < $signed(dataB_i);
            BrBge:         cmpTrue = $signed(dataA_i) >= $signed(dataB_i);
            BrBltu:        cmpTrue = dataA_i < dataB_i;
            BrBgeu:        cmpTrue = dataA_i >= dataB_i;
            BrJal, BrJalr: cmpTrue = 1'b1;
            default:       cmpTrue = 1'b0;
        endcase
        isJump         = branchCtr_i inside {BrJal, BrJalr};
        jumpSum        = dataA_i + offset_i;
        branchTarget_o = (branchCtr_i == BrJalr) ? {jumpSum[ADDR_W-1:1], 1'b0}
                                                 : pc_exe + offset_i;
    end

    always_comb begin
        stall_o               = rst && mdBusy;
        branchTaken_o         = rst && cmpTrue && !mdBusy && !mdDone;
        registerWriteEnable_o = rst && !stall_o && registerWriteEnable_i;
        dataWriteEnable_o     = rst && !stall_o && dataWriteEnable_i;
        regSelect_o           = regSelect_i;
        storeData_o           = dataB_i;
        if (mdDone) begin
            result_o = mdResult;
        end else if (isJump) begin
            result_o = pc_exe + ADDR_W'(4);
        end else begin
            result_o = aluResult;
        end
    end

endmodule
